// File: rtl/song_sequencer.sv
// song_sequencer: stores up to DEPTH {freq,dur} notes and plays them in order rep_count times.
// Optional `SONG_GAP_EN adds a one-tick silent GAP state after every played note.
module song_sequencer #(
  parameter int DEPTH  = 16,
  parameter int FREQ_W = 10,
  parameter int DUR_W  = 10,
  parameter int REP_W  = 8,
  parameter int TICK_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FREQ_W-1:0] wr_freq,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [AW:0]       song_len,
  input  logic [REP_W-1:0]  rep_count,
  input  logic [TICK_W-1:0] tick_div,
  input  logic              start,
  input  logic              stop,
  output logic [FREQ_W-1:0] freq_out,
  output logic              tone_en,
  output logic              makingMusic,
  output logic [AW-1:0]     note_idx,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  state_t                  state;
  logic [FREQ_W+DUR_W-1:0] mem [DEPTH];
  logic [AW:0]             len_l;
  logic [REP_W-1:0]        rep_l;
  logic [TICK_W-1:0]       div_l, tick;
  logic [DUR_W-1:0]        dur_rem;
  logic [REP_W:0]          pass, pass_nxt, adv_pass;
  logic [AW-1:0]           adv_idx;
  logic [FREQ_W-1:0]       rd_freq;
  logic [DUR_W-1:0]        rd_dur;
  logic                    last, fin, tick_wrap;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= {wr_freq, wr_dur};

  // Read word is captured into freq_out/dur_rem at the end of LOAD.
  assign {rd_freq, rd_dur} = mem[note_idx];

  always_comb begin
    last      = ({1'b0, note_idx} == len_l - 1'b1);
    pass_nxt  = pass + 1'b1;
    fin       = last && (pass_nxt == {1'b0, rep_l});
    adv_idx   = last ? '0 : note_idx + 1'b1;
    adv_pass  = last ? pass_nxt : pass;
    tick_wrap = (tick == div_l - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      freq_out    <= '0;
      tone_en     <= 1'b0;
      makingMusic <= 1'b0;
      note_idx    <= '0;
      done        <= 1'b0;
      len_l       <= '0;
      rep_l       <= '0;
      div_l       <= '0;
      tick        <= '0;
      dur_rem     <= '0;
      pass        <= '0;
    end else if (stop) begin
      state       <= IDLE;
      freq_out    <= '0;
      tone_en     <= 1'b0;
      makingMusic <= 1'b0;
      note_idx    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // makingMusic drops one cycle after returning here, after the done pulse
          makingMusic <= 1'b0;
          if (start && song_len != '0) begin
            state       <= LOAD;
            makingMusic <= 1'b1;
            len_l       <= song_len;
            rep_l       <= (rep_count == '0) ? REP_W'(1) : rep_count;
            div_l       <= (tick_div == '0) ? TICK_W'(1) : tick_div;
            note_idx    <= '0;
            pass        <= '0;
          end
        end
        LOAD: begin
          if (rd_dur == '0) begin
            note_idx <= adv_idx;
            pass     <= adv_pass;
            if (fin) begin
              state    <= DONE;
              tone_en  <= 1'b0;
              freq_out <= '0;
            end else state <= LOAD;
          end else begin
            freq_out <= rd_freq;
            tone_en  <= (rd_freq != '0);
            dur_rem  <= rd_dur;
            tick     <= '0;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (tick_wrap) begin
            tick <= '0;
            if (dur_rem == DUR_W'(1)) begin
`ifdef SONG_GAP_EN
              state   <= GAP;
              tone_en <= 1'b0;
`else
              note_idx <= adv_idx;
              pass     <= adv_pass;
              if (fin) begin
                state    <= DONE;
                tone_en  <= 1'b0;
                freq_out <= '0;
              end else state <= LOAD;
`endif
            end else dur_rem <= dur_rem - 1'b1;
          end else tick <= tick + 1'b1;
        end
`ifdef SONG_GAP_EN
        GAP: begin
          if (tick_wrap) begin
            tick     <= '0;
            note_idx <= adv_idx;
            pass     <= adv_pass;
            if (fin) begin
              state    <= DONE;
              freq_out <= '0;
            end else begin
              // LOAD bubble shows the previous note again, as without gaps
              state   <= LOAD;
              tone_en <= (freq_out != '0);
            end
          end else tick <= tick + 1'b1;
        end
`endif
        DONE: begin
          done    <= 1'b1;
          tone_en <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: table of single-note songs, hand corner cases,
// and random songs checked cycle-by-cycle against a trace built from the note list.
module tb_song_sequencer;
  localparam int DEPTH = 16, FREQ_W = 10, DUR_W = 10, REP_W = 8, TICK_W = 32, AW = 4;

  logic              clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [FREQ_W-1:0] wr_freq = '0;
  logic [DUR_W-1:0]  wr_dur = '0;
  logic [AW:0]       song_len = '0;
  logic [REP_W-1:0]  rep_count = '0;
  logic [TICK_W-1:0] tick_div = '0;
  logic [FREQ_W-1:0] freq_out;
  logic              tone_en, makingMusic, done;
  logic [AW-1:0]     note_idx;

  song_sequencer #(.DEPTH(DEPTH), .FREQ_W(FREQ_W), .DUR_W(DUR_W), .REP_W(REP_W), .TICK_W(TICK_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
    .wr_dur(wr_dur), .song_len(song_len), .rep_count(rep_count), .tick_div(tick_div),
    .start(start), .stop(stop), .freq_out(freq_out), .tone_en(tone_en),
    .makingMusic(makingMusic), .note_idx(note_idx), .done(done));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int nf[DEPTH], nd[DEPTH];

  typedef struct {int f; bit t; bit mm; bit dn; int idx; bit cf; bit ci;} ent_t;
  ent_t exq[$];

  typedef struct {int f; int d; int dv; int rp; int exp_done; int exp_tone; int exp_first;} vec_t;
  vec_t tv[6];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic write_note(input int i, input int f, input int d);
    wr_en = 1'b1; wr_addr = AW'(i); wr_freq = FREQ_W'(f); wr_dur = DUR_W'(d);
    nf[i] = f; nd[i] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected per-cycle outputs from the cycle after start is sampled.
  task automatic build_trace(input int len, input int rep, input int dv);
    int k, r, cf;
    bit ct, fk;
    k = (dv == 0) ? 1 : dv;
    r = (rep == 0) ? 1 : rep;
    cf = 0; ct = 1'b0; fk = 1'b0;
    exq.delete();
    for (int p = 0; p < r; p++)
      for (int i = 0; i < len; i++) begin
        exq.push_back('{cf, ct, 1'b1, 1'b0, i, fk, 1'b1});
        if (nd[i] != 0) begin
          cf = nf[i]; ct = (cf != 0); fk = 1'b1;
          for (int j = 0; j < nd[i] * k; j++) exq.push_back('{cf, ct, 1'b1, 1'b0, i, 1'b1, 1'b1});
`ifdef SONG_GAP_EN
          for (int j = 0; j < k; j++) exq.push_back('{cf, 1'b0, 1'b1, 1'b0, i, 1'b1, 1'b1});
`endif
        end
      end
    exq.push_back('{0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0});
    exq.push_back('{0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0});
    exq.push_back('{0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
  endtask

  task automatic run_song(input string tag, input int len, input int rep, input int dv, input bit perturb);
    ent_t e;
    song_len = (AW+1)'(len); rep_count = REP_W'(rep); tick_div = TICK_W'(dv);
    build_trace(len, rep, dv);
    pulse_start();
    for (int i = 0; i < exq.size(); i++) begin
      e = exq[i];
      if (e.cf) chk($sformatf("%s[%0d].freq", tag, i), 32'(freq_out), e.f);
      if (e.ci) chk($sformatf("%s[%0d].idx", tag, i), 32'(note_idx), e.idx);
      chk($sformatf("%s[%0d].tone", tag, i), 32'(tone_en), 32'(e.t));
      chk($sformatf("%s[%0d].mm", tag, i), 32'(makingMusic), 32'(e.mm));
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(e.dn));
      if (perturb) begin
        song_len  = (AW+1)'($urandom_range(0, 16));
        rep_count = REP_W'($urandom);
        tick_div  = TICK_W'($urandom_range(0, 5));
        start     = (i + 3 <= exq.size()) && ($urandom_range(0, 1) == 1);
      end
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, tc, ft, ndn, len;
    bit bad_mm, bad_dn, bad_t, seen;

`ifdef SONG_GAP_EN
    tv = '{'{9,3,4,1,19,12,2}, '{0,2,1,1,6,0,0}, '{5,2,1,3,14,8,2},
           '{5,0,1,2,4,0,0},   '{3,1,0,0,5,1,2}, '{7,0,1,255,257,0,0}};
`else
    tv = '{'{9,3,4,1,15,12,2}, '{0,2,1,1,5,0,0}, '{5,2,1,3,11,8,2},
           '{5,0,1,2,4,0,0},   '{3,1,0,0,4,1,2}, '{7,0,1,255,257,0,0}};
`endif

    step(); step();
    chk("rst.freq", 32'(freq_out), 0);
    chk("rst.tone", 32'(tone_en), 0);
    chk("rst.mm", 32'(makingMusic), 0);
    chk("rst.idx", 32'(note_idx), 0);
    chk("rst.done", 32'(done), 0);
    reset = 1'b0;
    step();

    // single-note songs: done cycle, tone cycles and first tone cycle after start
    for (int t = 0; t < 6; t++) begin
      write_note(0, tv[t].f, tv[t].d);
      song_len = 1; rep_count = REP_W'(tv[t].rp); tick_div = TICK_W'(tv[t].dv);
      pulse_start();
      dc = 0; tc = 0; ft = 0; ndn = 0;
      for (int c = 1; c < 300; c++) begin
        if (done) begin ndn++; if (dc == 0) dc = c; end
        if (tone_en) begin tc++; if (ft == 0) ft = c; end
        if (dc != 0 && c > dc + 2) break;
        step();
      end
      chk($sformatf("vec%0d.done_cycle", t), dc, tv[t].exp_done);
      chk($sformatf("vec%0d.tone_cycles", t), tc, tv[t].exp_tone);
      chk($sformatf("vec%0d.first_tone", t), ft, tv[t].exp_first);
      chk($sformatf("vec%0d.done_pulses", t), ndn, 1);
      chk($sformatf("vec%0d.mm_after", t), 32'(makingMusic), 0);
    end

    // four-note song with a skipped note, two passes
    write_note(0, 7, 15); write_note(1, 12, 0); write_note(2, 1, 5); write_note(3, 7, 15);
    run_song("song2", 4, 2, 1, 1'b0);
    chk("song2.idle_mm", 32'(makingMusic), 0);

`ifdef SONG_GAP_EN
    write_note(0, 4, 2); write_note(1, 6, 2);
    run_song("gap", 2, 1, 3, 1'b0);
`endif

    // reset mid-PLAY
    write_note(0, 9, 3);
    song_len = 1; rep_count = 1; tick_div = 4;
    pulse_start();
    repeat (5) step();
    chk("midrst.pre_tone", 32'(tone_en), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst.freq", 32'(freq_out), 0);
    chk("midrst.tone", 32'(tone_en), 0);
    chk("midrst.mm", 32'(makingMusic), 0);
    chk("midrst.idx", 32'(note_idx), 0);
    chk("midrst.done", 32'(done), 0);
    step();
    chk("midrst.stay_idle", 32'(makingMusic), 0);

    // stop during the second note
    write_note(0, 4, 5); write_note(1, 6, 5);
    song_len = 2; rep_count = 1; tick_div = 1;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (note_idx == 1 && tone_en && freq_out == 6) seen = 1'b1;
      else step();
    end
    chk("stop.reached_note2", 32'(seen), 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop.mm", 32'(makingMusic), 0);
    chk("stop.tone", 32'(tone_en), 0);
    bad_mm = 1'b0; bad_dn = 1'b0;
    repeat (20) begin
      step();
      if (makingMusic) bad_mm = 1'b1;
      if (done) bad_dn = 1'b1;
    end
    chk("stop.no_music", 32'(bad_mm), 0);
    chk("stop.no_done", 32'(bad_dn), 0);

    // stop wins over start in the same cycle
    song_len = 2; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("stopstart.mm", 32'(makingMusic), 0);
    step();
    chk("stopstart.mm2", 32'(makingMusic), 0);

    // start with an empty song does nothing
    song_len = 0;
    pulse_start();
    bad_mm = 1'b0; bad_dn = 1'b0; bad_t = 1'b0;
    repeat (6) begin
      if (makingMusic) bad_mm = 1'b1;
      if (done) bad_dn = 1'b1;
      if (tone_en) bad_t = 1'b1;
      step();
    end
    chk("len0.mm", 32'(bad_mm), 0);
    chk("len0.done", 32'(bad_dn), 0);
    chk("len0.tone", 32'(bad_t), 0);

    // random songs with config inputs and start wiggling during playback
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) write_note(i, $urandom_range(0, 7), $urandom_range(0, 3));
      run_song($sformatf("rnd%0d", r), len, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
